// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
// AHB-Lite bus bundle between the JTAG debug bridge (master) and the SRAM
// slave. Clock and reset are kept outside the bundle as plain ports.
//
// Signals:
//   HSEL    master->slave  slave select
//   HADDR   master->slave  byte address (address phase)
//   HTRANS  master->slave  transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE  master->slave  1 = write (address phase)
//   HWDATA  master->slave  write data (data phase)
//   HRDATA  slave->master  read data
//   HREADY  slave->master  transfer done / ready for next address phase
//   HRESP   slave->master  0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// Word-addressed AHB-Lite SRAM target for the JTAG debug path. Decodes one
// aligned window of MEM_WORDS 32-bit words at BASE_ADDR, performs single-word
// reads/writes with WAIT_STATES HREADY-low cycles per data phase, and answers
// out-of-window or unaligned addresses with a two-cycle ERROR response.
//
// Ports:
//   TCK      in   bus clock, all logic on posedge
//   HRESETn  in   synchronous active-low reset
//   bus      ahb_sram_slave_if.slave (HSEL/HADDR/HTRANS/HWRITE/HWDATA in,
//                                     HRDATA/HREADY/HRESP out)
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer in flight, ready for an address phase
// DATA  | OKAY data phase; r_cnt counts remaining wait cycles
// ERR1  | first ERROR cycle (HRESP=1, HREADY=0)
// ERR2  | second ERROR cycle (HRESP=1, HREADY=1), accepts like IDLE
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             TCK,
    input  logic             HRESETn,
    ahb_sram_slave_if.slave  bus
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cnt;
    logic [AW-1:0]   r_idx;
    logic            r_write;
    logic [31:0]     r_hrdata;
    logic [31:0]     r_mem [MEM_WORDS];

    logic            w_hready;
    logic            w_hresp;
    logic            w_accept;
    logic            w_addr_ok;
    logic [AW-1:0]   w_idx;
    logic            w_final;
    logic            w_commit;
    logic            w_rd_now;
    logic            w_rd_late;
    logic [31:0]     w_rd_data;
    logic            w_unused_htrans0;

    // SEQ and NONSEQ are treated alike, so only HTRANS[1] matters.
    assign w_unused_htrans0 = bus.HTRANS[0];

    // BASE_ADDR is aligned to the window size, so the window test reduces to
    // matching the upper address bits, and the word index is simply the
    // address bits just above the byte offset.
    assign w_addr_ok = (bus.HADDR[31:AW+2] == BASE_ADDR[31:AW+2]) &&
                       (bus.HADDR[1:0] == 2'b00);
    assign w_idx     = bus.HADDR[AW+1:2];

    assign w_final   = (r_state == S_DATA) && (r_cnt == 3'd0);
    assign w_commit  = w_final && r_write;
    assign w_accept  = w_hready && bus.HSEL && bus.HTRANS[1];

    // ---------------- state register ----------------
    always_ff @(posedge TCK) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ERR2: begin
                if (w_accept) begin
                    w_state_nxt = w_addr_ok ? S_DATA : S_ERR1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (r_cnt != 3'd0) begin
                    w_state_nxt = S_DATA;
                end else if (w_accept) begin
                    w_state_nxt = w_addr_ok ? S_DATA : S_ERR1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR1:  w_state_nxt = S_ERR2;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output decode (registered state only) ----------------
    always_comb begin
        w_hready = 1'b0;
        w_hresp  = 1'b0;
        case (r_state)
            S_IDLE: w_hready = 1'b1;
            S_DATA: w_hready = (r_cnt == 3'd0);
            S_ERR1: w_hresp  = 1'b1;
            S_ERR2: begin
                w_hready = 1'b1;
                w_hresp  = 1'b1;
            end
            default: begin
                w_hready = 1'b1;
                w_hresp  = 1'b0;
            end
        endcase
    end

    assign bus.HREADY = w_hready;
    assign bus.HRESP  = w_hresp;
    assign bus.HRDATA = r_hrdata;

    // Read data is loaded on the edge that enters the final data cycle: the
    // accept edge itself when there are no wait states, otherwise the edge
    // where the counter steps from 1 to 0.
    assign w_rd_now  = ZERO_WAIT && w_accept && w_addr_ok && !bus.HWRITE;
    assign w_rd_late = (r_state == S_DATA) && !r_write && (r_cnt == 3'd1);

    // A zero-wait read accepted while the previous write commits would see
    // the stale array word, so the incoming write data is forwarded.
    always_comb begin
        if (w_rd_late) begin
            w_rd_data = r_mem[r_idx];
        end else if (w_commit && (r_idx == w_idx)) begin
            w_rd_data = bus.HWDATA;
        end else begin
            w_rd_data = r_mem[w_idx];
        end
    end

    // ---------------- datapath registers ----------------
    // An accept can only happen with r_cnt already 0 (IDLE, ERR2 or the final
    // DATA cycle), so loading and decrementing never collide.
    always_ff @(posedge TCK) begin
        if (!HRESETn) begin
            r_cnt    <= 3'd0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_hrdata <= 32'h0;
        end else begin
            if (w_accept && w_addr_ok) begin
                r_cnt   <= WS;
                r_idx   <= w_idx;
                r_write <= bus.HWRITE;
            end else if ((r_state == S_DATA) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_rd_now || w_rd_late) begin
                r_hrdata <= w_rd_data;
            end
        end
    end

    // Array is deliberately not reset so contents survive HRESETn; a write
    // committing on a reset edge is dropped.
    always_ff @(posedge TCK) begin
        if (HRESETn && w_commit) begin
            r_mem[r_idx] <= bus.HWDATA;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance and one
// three-wait instance share stimulus; `sel` picks which one is active.
module tb_ahb_sram_slave;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        t_hsel;
    logic [31:0] t_haddr;
    logic [1:0]  t_htrans;
    logic        t_hwrite;
    logic [31:0] t_hwdata;

    logic        o_ready;
    logic        o_resp;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    ahb_sram_slave_if if0 ();
    ahb_sram_slave_if if3 ();

    assign if0.HSEL   = t_hsel;
    assign if0.HADDR  = t_haddr;
    assign if0.HTRANS = sel ? 2'b00 : t_htrans;
    assign if0.HWRITE = t_hwrite;
    assign if0.HWDATA = t_hwdata;
    assign if3.HSEL   = t_hsel;
    assign if3.HADDR  = t_haddr;
    assign if3.HTRANS = sel ? t_htrans : 2'b00;
    assign if3.HWRITE = t_hwrite;
    assign if3.HWDATA = t_hwdata;

    assign o_ready = sel ? if3.HREADY : if0.HREADY;
    assign o_resp  = sel ? if3.HRESP  : if0.HRESP;
    assign o_rdata = sel ? if3.HRDATA : if0.HRDATA;

    ahb_sram_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_w0 (
        .TCK(clk), .HRESETn(rst_n), .bus(if0)
    );
    ahb_sram_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_w3 (
        .TCK(clk), .HRESETn(rst_n), .bus(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on negedge; outputs are sampled on negedge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int waits, output logic resp_first, output logic resp_last,
                        output logic [31:0] rdata);
        @(negedge clk);
        t_hsel   = 1'b1;
        t_haddr  = addr;
        t_htrans = 2'b10;
        t_hwrite = wr;
        @(posedge clk);
        @(negedge clk);
        t_htrans   = 2'b00;
        t_hwrite   = 1'b0;
        t_hwdata   = wdata;
        resp_first = o_resp;
        waits      = 0;
        while (o_ready !== 1'b1 && waits < 16) begin
            @(posedge clk);
            @(negedge clk);
            waits++;
        end
        resp_last = o_resp;
        rdata     = o_rdata;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (if0.HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready_w0: got %b expected 1", if0.HREADY); end
        checks++; if (if0.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp_w0: got %b expected 0", if0.HRESP); end
        checks++; if (if0.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata_w0: got %h expected 00000000", if0.HRDATA); end
        checks++; if (if3.HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready_w3: got %b expected 1", if3.HREADY); end
        checks++; if (if3.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp_w3: got %b expected 0", if3.HRESP); end
        checks++; if (if3.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata_w3: got %h expected 00000000", if3.HRDATA); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_rw();
        int w; logic rf, rl; logic [31:0] rd;
        sel = 1'b0;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, w, rf, rl, rd);
        checks++; if (w !== 0) begin errors++; $display("FAIL basic_wr_waits: got %0d expected 0", w); end
        checks++; if (rl !== 1'b0) begin errors++; $display("FAIL basic_wr_resp: got %b expected 0", rl); end
        xfer(1'b0, 32'h10, 32'h0, w, rf, rl, rd);
        checks++; if (w !== 0) begin errors++; $display("FAIL basic_rd_waits: got %0d expected 0", w); end
        checks++; if (rl !== 1'b0) begin errors++; $display("FAIL basic_rd_resp: got %b expected 0", rl); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int w; logic rf, rl; logic [31:0] rd;
        sel = 1'b0;
        @(negedge clk);
        t_hsel = 1'b1; t_haddr = 32'h20; t_htrans = 2'b10; t_hwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_hwdata = 32'h1234_5678;
        t_haddr  = 32'h20; t_htrans = 2'b10; t_hwrite = 1'b0;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %b expected 1", o_ready); end
        @(posedge clk);
        @(negedge clk);
        t_htrans = 2'b00;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready: got %b expected 1", o_ready); end
        checks++; if (o_resp !== 1'b0) begin errors++; $display("FAIL b2b_rd_resp: got %b expected 0", o_resp); end
        checks++; if (o_rdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_fwd_data: got %h expected 12345678", o_rdata); end
        xfer(1'b0, 32'h20, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL b2b_mem_data: got %h expected 12345678", rd); end
    endtask

    task automatic test_error();
        int w; logic rf, rl; logic [31:0] rd;
        sel = 1'b0;
        xfer(1'b1, 32'h0, 32'h1111_1111, w, rf, rl, rd);
        xfer(1'b0, 32'h400, 32'h0, w, rf, rl, rd);
        checks++; if (w !== 1) begin errors++; $display("FAIL err_range_waits: got %0d expected 1", w); end
        checks++; if (rf !== 1'b1) begin errors++; $display("FAIL err_range_resp1: got %b expected 1", rf); end
        checks++; if (rl !== 1'b1) begin errors++; $display("FAIL err_range_resp2: got %b expected 1", rl); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL err_range_rdata: got %h expected 12345678", rd); end
        xfer(1'b0, 32'h6, 32'h0, w, rf, rl, rd);
        checks++; if (w !== 1) begin errors++; $display("FAIL err_unalign_waits: got %0d expected 1", w); end
        checks++; if (rf !== 1'b1 || rl !== 1'b1) begin errors++; $display("FAIL err_unalign_resp: got %b%b expected 11", rf, rl); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL err_unalign_rdata: got %h expected 12345678", rd); end
        xfer(1'b1, 32'h400, 32'h9999_9999, w, rf, rl, rd);
        checks++; if (rf !== 1'b1 || rl !== 1'b1 || w !== 1) begin errors++; $display("FAIL err_wr_resp: got %b%b waits %0d expected 11 waits 1", rf, rl, w); end
        xfer(1'b1, 32'h12, 32'h7777_7777, w, rf, rl, rd);
        xfer(1'b0, 32'h0, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL err_mem0_intact: got %h expected 11111111", rd); end
        xfer(1'b0, 32'h10, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem4_intact: got %h expected deadbeef", rd); end
    endtask

    task automatic test_idle_busy();
        int w; logic rf, rl; logic [31:0] rd;
        logic [1:0] kinds [2];
        kinds[0] = 2'b01;
        kinds[1] = 2'b00;
        sel = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                t_hsel = 1'b1; t_haddr = 32'h10; t_htrans = kinds[k];
                t_hwrite = 1'b1; t_hwdata = 32'hFFFF_FFFF;
                @(posedge clk);
                @(negedge clk);
                checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL idle_busy_ready: htrans %b got %b expected 1", kinds[k], o_ready); end
                checks++; if (o_resp !== 1'b0) begin errors++; $display("FAIL idle_busy_resp: htrans %b got %b expected 0", kinds[k], o_resp); end
            end
        end
        t_htrans = 2'b00; t_hwrite = 1'b0;
        xfer(1'b0, 32'h10, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_busy_mem4: got %h expected deadbeef", rd); end
    endtask

    task automatic test_wait_states();
        int w; logic rf, rl; logic [31:0] rd;
        sel = 1'b1;
        xfer(1'b1, 32'h30, 32'hCAFE_F00D, w, rf, rl, rd);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws_pre_waits: got %0d expected 3", w); end
        xfer(1'b1, 32'h8, 32'hA5A5_A5A5, w, rf, rl, rd);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws_wr_waits: got %0d expected 3", w); end
        checks++; if (rf !== 1'b0 || rl !== 1'b0) begin errors++; $display("FAIL ws_wr_resp: got %b%b expected 00", rf, rl); end
        xfer(1'b0, 32'h8, 32'h0, w, rf, rl, rd);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws_rd_waits: got %0d expected 3", w); end
        checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ws_rd_data: got %h expected a5a5a5a5", rd); end
    endtask

    task automatic test_reset_mid_write();
        int w; logic rf, rl; logic [31:0] rd;
        sel = 1'b1;
        @(negedge clk);
        t_hsel = 1'b1; t_haddr = 32'h30; t_htrans = 2'b10; t_hwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_htrans = 2'b00; t_hwrite = 1'b0; t_hwdata = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rstmid_wait2_ready: got %b expected 0", o_ready); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", o_ready); end
        checks++; if (o_resp !== 1'b0) begin errors++; $display("FAIL rstmid_resp: got %b expected 0", o_resp); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 00000000", o_rdata); end
        xfer(1'b0, 32'h30, 32'h0, w, rf, rl, rd);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstmid_mem_kept: got %h expected cafef00d", rd); end
        checks++; if (w !== 3) begin errors++; $display("FAIL rstmid_rd_waits: got %0d expected 3", w); end
    endtask

    initial begin
        rst_n    = 1'b1;
        sel      = 1'b0;
        t_hsel   = 1'b1;
        t_haddr  = 32'h0;
        t_htrans = 2'b00;
        t_hwrite = 1'b0;
        t_hwdata = 32'h0;
        test_reset();
        test_basic_rw();
        test_back_to_back();
        test_error();
        test_idle_busy();
        test_wait_states();
        test_reset_mid_write();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
